// File: rtl/echo_detector.sv
// Ultrasonic echo detector: rectify, moving-average and threshold ADC samples after a burst,
// reporting time-of-flight 2 cycles after the detecting sample, or a timeout pulse.
module echo_detector #(
  parameter int DATA_WIDTH     = 8,
  parameter int AVG_DEPTH      = 4,
  parameter int BLANK_SAMPLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TOF_WIDTH      = 24
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [DATA_WIDTH-1:0] threshold_in,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid_in,
  output logic                  busy_out,
  output logic [TOF_WIDTH-1:0]  tof_out,
  output logic                  tof_valid_out,
  output logic                  timeout_out,
  output logic [DATA_WIDTH-1:0] peak_out
);

  localparam int AVG_SHIFT = $clog2(AVG_DEPTH);
  localparam int SUM_W     = DATA_WIDTH + AVG_SHIFT;
  localparam int BCNT_W    = $clog2(BLANK_SAMPLES + 1);
  localparam logic [DATA_WIDTH-1:0] MID        = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [TOF_WIDTH-1:0]  LAST_CNT   = TOF_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [BCNT_W-1:0]     LAST_BLANK = BCNT_W'(BLANK_SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, BLANK, LISTEN, REPORT} state_e;

  state_e                                 state_q, state_d;
  logic [DATA_WIDTH-1:0]                  thr_q, thr_d;
  logic [TOF_WIDTH-1:0]                   cnt_q, cnt_d;
  logic [BCNT_W-1:0]                      bcnt_q, bcnt_d;
  logic [AVG_DEPTH-1:0][DATA_WIDTH-1:0]   win_q, win_d;
  logic [SUM_W-1:0]                       sum_q, sum_d;
  logic [DATA_WIDTH-1:0]                  peak_q, peak_d;
  logic                                   pend_q, pend_d;
  logic [TOF_WIDTH-1:0]                   smp_cnt_q, smp_cnt_d;
  logic [TOF_WIDTH-1:0]                   tof_q, tof_d;
  logic [DATA_WIDTH-1:0]                  peak_out_q, peak_out_d;
  logic                                   timeout_q, timeout_d;

  logic [DATA_WIDTH-1:0] rect, avg, peak_nxt;
  logic                  busy, smp_acc, cmp, hit, at_last;

  assign rect     = (sample_in >= MID) ? (sample_in - MID) : (MID - sample_in);
  assign avg      = DATA_WIDTH'(sum_q >> AVG_SHIFT);
  assign busy     = (state_q != IDLE);
  assign smp_acc  = sample_valid_in && ((state_q == BLANK) || (state_q == LISTEN));
  // pend_q marks the cycle after a LISTEN sample, when sum_q already includes it
  assign cmp      = (state_q == LISTEN) && pend_q;
  assign hit      = cmp && (avg >= thr_q);
  assign peak_nxt = (cmp && (avg > peak_q)) ? avg : peak_q;
  assign at_last  = (cnt_q == LAST_CNT);

  always_comb begin
    state_d    = state_q;
    thr_d      = thr_q;
    cnt_d      = busy ? cnt_q + 1'b1 : cnt_q;
    bcnt_d     = bcnt_q;
    win_d      = win_q;
    sum_d      = sum_q;
    peak_d     = peak_nxt;
    pend_d     = smp_acc && (state_q == LISTEN);
    smp_cnt_d  = smp_acc ? cnt_q : smp_cnt_q;
    tof_d      = tof_q;
    peak_out_d = peak_out_q;
    timeout_d  = 1'b0;

    if (smp_acc) begin
      win_d = {win_q[AVG_DEPTH-2:0], rect};
      sum_d = sum_q + SUM_W'(rect) - SUM_W'(win_q[AVG_DEPTH-1]);
    end

    case (state_q)
      IDLE: begin
        if (start_in) begin
          thr_d   = threshold_in;
          cnt_d   = '0;
          bcnt_d  = '0;
          win_d   = '0;
          sum_d   = '0;
          peak_d  = '0;
          state_d = BLANK;
        end
      end
      BLANK: begin
        if (at_last) begin
          timeout_d  = 1'b1;
          peak_out_d = peak_nxt;
          state_d    = IDLE;
        end else if (smp_acc) begin
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == LAST_BLANK) state_d = LISTEN;
        end
      end
      LISTEN: begin
        // A hit on the final listen cycle takes priority over the timeout
        if (hit) begin
          tof_d      = smp_cnt_q;
          peak_out_d = peak_nxt;
          state_d    = REPORT;
        end else if (at_last) begin
          timeout_d  = 1'b1;
          peak_out_d = peak_nxt;
          state_d    = IDLE;
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      thr_q      <= '0;
      cnt_q      <= '0;
      bcnt_q     <= '0;
      win_q      <= '0;
      sum_q      <= '0;
      peak_q     <= '0;
      pend_q     <= 1'b0;
      smp_cnt_q  <= '0;
      tof_q      <= '0;
      peak_out_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      thr_q      <= thr_d;
      cnt_q      <= cnt_d;
      bcnt_q     <= bcnt_d;
      win_q      <= win_d;
      sum_q      <= sum_d;
      peak_q     <= peak_d;
      pend_q     <= pend_d;
      smp_cnt_q  <= smp_cnt_d;
      tof_q      <= tof_d;
      peak_out_q <= peak_out_d;
      timeout_q  <= timeout_d;
    end
  end

  assign busy_out      = busy;
  assign tof_out       = tof_q;
  assign tof_valid_out = (state_q == REPORT);
  assign timeout_out   = timeout_q;
  assign peak_out      = peak_out_q;

endmodule

// File: tb/tb_echo_detector.sv
// Bench for echo_detector: table of measurement scenarios with a result scoreboard,
// plus reset-at-start and reset-mid-measurement sequences.
module tb_echo_detector;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic [7:0]  threshold_in;
  logic [7:0]  sample_in;
  logic        sample_valid_in;
  logic        busy_out;
  logic [23:0] tof_out;
  logic        tof_valid_out;
  logic        timeout_out;
  logic [7:0]  peak_out;

  echo_detector #(
    .DATA_WIDTH(8), .AVG_DEPTH(4), .BLANK_SAMPLES(4), .TIMEOUT_CYCLES(1000), .TOF_WIDTH(24)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .threshold_in(threshold_in),
    .sample_in(sample_in), .sample_valid_in(sample_valid_in), .busy_out(busy_out),
    .tof_out(tof_out), .tof_valid_out(tof_valid_out), .timeout_out(timeout_out),
    .peak_out(peak_out)
  );

  always #5 clk_in = ~clk_in;

  // Samples k<4 are code 128, the last is last_code, the rest mid_code; sample k at count t0+100k.
  typedef struct {
    logic [7:0]  thr;
    int          t0;
    int          nsamp;
    logic [7:0]  mid_code;
    logic [7:0]  last_code;
    bit          restart;
    bit          noise;
    bit          hit;
    int          exp_cnt;
    logic [23:0] exp_tof;
    logic [7:0]  exp_peak;
  } vec_t;

  typedef struct {
    bit          hit;
    int          cnt;
    logic [23:0] tof;
    logic [7:0]  peak;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[8];
  logic [23:0] last_tof = '0;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic run_vec(input vec_t v, input int abort_at);
    exp_t e;
    int   seen = 0;
    int   post = -1;
    int   k;
    @(negedge clk_in);
    sample_valid_in = v.noise;
    sample_in       = 8'hFF;
    @(negedge clk_in);
    start_in     = 1'b1;
    threshold_in = v.thr;
    sb.push_back('{v.hit, v.hit ? v.exp_cnt : 1000, v.hit ? v.exp_tof : last_tof, v.exp_peak});
    for (int cnt = 0; cnt < 1100; cnt++) begin
      @(negedge clk_in);
      if (cnt == 0) chk("busy_at_start", busy_out, 1);
      if (cnt == post) chk("busy_after_result", busy_out, 0);
      if (tof_valid_out || timeout_out) begin
        seen++;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("tof_valid_out", tof_valid_out, e.hit);
          chk("timeout_out", timeout_out, !e.hit);
          chk("result_count", cnt, e.cnt);
          chk("tof_out", tof_out, e.tof);
          chk("peak_out", peak_out, e.peak);
          if (e.hit) last_tof = e.tof;
          post = cnt + 1;
        end
      end
      if (cnt == abort_at) begin
        rst_in = 1'b0;
        #1;
        chk("abort_outputs_zero", {busy_out, tof_valid_out, timeout_out, tof_out, peak_out}, 0);
        sb.delete();
        last_tof = '0;
      end
      if (abort_at >= 0 && cnt == abort_at + 5) rst_in = 1'b1;
      start_in        = v.restart && (cnt == 300);
      threshold_in    = start_in ? 8'd0 : v.thr;
      sample_valid_in = 1'b0;
      if (cnt >= v.t0 && (cnt - v.t0) % 100 == 0 && (cnt - v.t0) / 100 < v.nsamp) begin
        k               = (cnt - v.t0) / 100;
        sample_valid_in = 1'b1;
        sample_in       = (k < 4) ? 8'd128 : ((k == v.nsamp - 1) ? v.last_code : v.mid_code);
      end
    end
    chk("pulse_count", seen, (abort_at >= 0) ? 0 : 1);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    //           thr    t0  n  mid     last    rst noise hit cnt   tof      peak
    vecs[0] = '{8'd50, 99,  6, 8'd228, 8'd228, 0, 0, 1,  601, 24'd599, 8'd50};
    vecs[1] = '{8'd50, 99, 10, 8'd128, 8'd128, 0, 0, 0, 1000, 24'd0,   8'd0};
    vecs[2] = '{8'd0,  99, 10, 8'd128, 8'd128, 0, 0, 1,  501, 24'd499, 8'd0};
    vecs[3] = '{8'd50, 99,  6, 8'd228, 8'd228, 1, 1, 1,  601, 24'd599, 8'd50};
    vecs[4] = '{8'd64, 99,  6, 8'd0,   8'd255, 0, 0, 0, 1000, 24'd0,   8'd63};
    vecs[5] = '{8'd51, 99,  9, 8'd228, 8'd228, 0, 0, 1,  701, 24'd699, 8'd75};
    vecs[6] = '{8'd31, 98, 10, 8'd128, 8'd255, 0, 0, 1, 1000, 24'd998, 8'd31};
    vecs[7] = '{8'd31, 99, 10, 8'd128, 8'd255, 0, 0, 0, 1000, 24'd0,   8'd0};

    rst_in          = 1'b0;
    start_in        = 1'b0;
    threshold_in    = '0;
    sample_in       = '0;
    sample_valid_in = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("reset_busy", busy_out, 0);
    chk("reset_tof_valid", tof_valid_out, 0);
    chk("reset_timeout", timeout_out, 0);
    chk("reset_tof", tof_out, 0);
    chk("reset_peak", peak_out, 0);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], -1);

    run_vec(vecs[0], 550);
    run_vec(vecs[0], -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/echo_detector.md
ECHO_DETECTOR -- requirements
Module: echo_detector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: ADC sample width.
REQ-002 SHALL have parameter AVG_DEPTH, default 4: moving-average window in samples, power of two, >= 2.
REQ-003 SHALL have parameter BLANK_SAMPLES, default 4: samples ignored for detection after start, >= AVG_DEPTH.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1000: listen window in clk_in cycles, >= 2.
REQ-005 SHALL have parameter TOF_WIDTH, default 24: width of time-of-flight count, >= $clog2(TIMEOUT_CYCLES).
REQ-006 SHALL have port clk_in input 1: the single clock; all logic on posedge.
REQ-007 SHALL have port rst_in input 1: asynchronous, active-low reset.
REQ-008 SHALL have port start_in input 1: single-cycle pulse marking ultrasonic burst emission.
REQ-009 SHALL have port threshold_in input DATA_WIDTH: detection threshold, latched at start.
REQ-010 SHALL have port sample_in input DATA_WIDTH: unsigned ADC code from SPI reader.
REQ-011 SHALL have port sample_valid_in input 1: one-cycle strobe qualifying sample_in.
REQ-012 SHALL have port busy_out output 1: high while a measurement is in progress.
REQ-013 SHALL have port tof_out output TOF_WIDTH: cycle count of detecting sample.
REQ-014 SHALL have port tof_valid_out output 1: one-cycle pulse, echo detected.
REQ-015 SHALL have port timeout_out output 1: one-cycle pulse, no echo in window.
REQ-016 SHALL have port peak_out output DATA_WIDTH: largest average seen in LISTEN, valid with either result pulse.

Function
REQ-017 SHALL implement states IDLE, BLANK, LISTEN, REPORT; busy_out high in BLANK, LISTEN and REPORT.
REQ-018 IDLE: start_in high SHALL latch threshold_in, clear cycle counter, sample counter, window, sum and peak, and go to BLANK; sample_valid_in in IDLE (including the start cycle) SHALL be ignored.
REQ-019 Cycle counter SHALL read 0 on the first cycle after start acceptance and increment by 1 every cycle while busy.
REQ-020 Each accepted sample SHALL be rectified as |sample_in - 2^(DATA_WIDTH-1)| in DATA_WIDTH bits (code 0 -> 128, code 255 -> 127 at width 8).
REQ-021 Rectified value SHALL enter a AVG_DEPTH-entry shift window; sum (DATA_WIDTH+log2(AVG_DEPTH) bits) SHALL add new and subtract evicted entry in the same cycle; average = sum >> log2(AVG_DEPTH), no rounding.
REQ-022 BLANK: samples SHALL update the window but never compare; after the BLANK_SAMPLES-th sample, go to LISTEN.
REQ-023 LISTEN: on the cycle after each accepted sample, registered average SHALL be compared (>=) to latched threshold and peak updated if larger.
REQ-024 On a hit, tof_out SHALL hold the cycle-counter value from the cycle that sample was accepted; tof_valid_out SHALL pulse exactly 2 cycles after that acceptance, via REPORT, then IDLE.
REQ-025 When cycle counter equals TIMEOUT_CYCLES-1 in BLANK or LISTEN with no pending hit, timeout_out SHALL pulse next cycle and FSM return to IDLE; tof_out unchanged.
REQ-026 Hit and timeout in the same cycle: hit SHALL win; timeout_out not asserted.
REQ-027 start_in while busy SHALL be ignored, no restart.
REQ-028 tof_valid_out and timeout_out SHALL never be high together and each high at most one cycle per measurement.
REQ-029 tof_out and peak_out SHALL hold last reported values until the next report.

Reset
REQ-030 rst_in low SHALL immediately force IDLE, busy_out 0, tof_valid_out 0, timeout_out 0, tof_out 0, peak_out 0, all counters, window, sum and latched threshold 0, independent of clk_in.
REQ-031 Reset mid-measurement SHALL abort without any result pulse; first start_in after release SHALL begin a clean measurement.

Verification
REQ-032 Defaults, threshold 50, samples every 100 cycles (counts 99,199,...): four of 128 then 228 -> avg 25 at count 499, 50 at 599; tof_valid_out at count 601, tof_out=599, peak_out=50.
REQ-033 Threshold 50, all samples 128 -> timeout_out one pulse at count 1000, no tof_valid_out, peak_out=0, busy_out 0 after.
REQ-034 Threshold 0 -> hit on the fifth sample (first LISTEN sample), tof_out=499.
REQ-035 start_in repeated at count 300 and sample_valid_in during IDLE -> no effect; result identical to REQ-032.
REQ-036 rst_in low at count 550 of REQ-032 run -> all outputs 0 at once, no pulses; rerun after release reproduces REQ-032.
REQ-037 Samples 0 and 255 in LISTEN, threshold 64 -> rectified 128 and 127, sum 255, avg 63 (no hit), peak_out=63 at timeout.
